// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity modes and baud divisor table
// for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Clock cycles per bit, integer-truncated.
  function automatic logic [31:0] baud_div(
    input logic [2:0]  sel,
    input int unsigned clk_hz
  );
    logic [31:0] d;
    unique case (sel)
      3'b000:  d = clk_hz / 300;
      3'b001:  d = clk_hz / 1200;
      3'b010:  d = clk_hz / 4800;
      3'b011:  d = clk_hz / 9600;
      3'b100:  d = clk_hz / 19200;
      3'b101:  d = clk_hz / 38400;
      3'b110:  d = clk_hz / 57600;
      default: d = clk_hz / 115200;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; ports push/pop/wdata in, rdata out,
// registered full/empty flags and a one-cycle ovf pulse on rejected push.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         ovf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q, ovf_q;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;
  assign cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  assign rdata_o = mem[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
      ovf_q   <= push_i && full_q;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed UART transmitter (start/data/parity/stop).
// Ports: baud_sel, parity_sel (UART_TX_PARITY_EN only), Tx_DATA/WR/EN in; TxD, Tx_BUSY/FULL/EMPTY/OVF out.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        baud_sel,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]        parity_sel,
`endif
  input  logic [DATA_W-1:0] Tx_DATA,
  input  logic              Tx_WR,
  input  logic              Tx_EN,
  output logic              TxD,
  output logic              Tx_BUSY,
  output logic              Tx_FULL,
  output logic              Tx_EMPTY,
  output logic              Tx_OVF
);

  // Wide enough for the full stop period at the slowest rate.
  localparam int unsigned CNT_W = $clog2(STOP_BITS * (CLK_HZ / 300) + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, div_q, stop_lim;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] sh_q, head;
  logic              txd_q, busy_q;
  logic              pop, bit_end, stop_end;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_bit_q;
`endif

  uart_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (Tx_WR),
    .pop_i   (pop),
    .wdata_i (Tx_DATA),
    .rdata_o (head),
    .full_o  (Tx_FULL),
    .empty_o (Tx_EMPTY),
    .ovf_o   (Tx_OVF)
  );

  assign pop      = (state_q == S_IDLE) && Tx_EN && !Tx_EMPTY;
  assign stop_lim = CNT_W'(STOP_BITS) * div_q;
  assign bit_end  = (cnt_q == div_q - CNT_W'(1));
  assign stop_end = (cnt_q == stop_lim - CNT_W'(1));

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            sh_q    <= head;
            div_q   <= CNT_W'(baud_div(baud_sel, CLK_HZ));
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= (parity_sel == PAR_EVEN) ||
                         (parity_sel == PAR_ODD);
            par_bit_q <= (^head) ^ (parity_sel == PAR_ODD);
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= sh_q[0];
            sh_q    <= sh_q >> 1;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                txd_q   <= par_bit_q;
                state_q <= S_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              txd_q <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (stop_end) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for uart_tx_buffered at 50 MHz,
// 115200 baud (434 cycles/bit), 8 data bits, FIFO depth 4, 1 stop bit.
module tb_uart_tx_buffered;

  localparam int DIV = 434;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_sel = 3'b111;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_sel = 2'b00;
`endif
  logic [7:0] Tx_DATA = '0;
  logic       Tx_WR = 1'b0;
  logic       Tx_EN = 1'b1;
  logic       TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVF;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_buffered dut (
    .clk        (clk),
    .reset      (reset),
    .baud_sel   (baud_sel),
`ifdef UART_TX_PARITY_EN
    .parity_sel (parity_sel),
`endif
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_FULL    (Tx_FULL),
    .Tx_EMPTY   (Tx_EMPTY),
    .Tx_OVF     (Tx_OVF)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic send(input logic [7:0] d);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR   = 1'b0;
  endtask

  // Waits for the start bit, samples mid-bit, counts low/busy cycles,
  // and returns at the first cycle after the frame.
  task automatic rx_frame(input int nb, output logic [15:0] bits,
                          output int lowc, output int busyc,
                          output int waited);
    waited = 0;
    while (TxD !== 1'b0 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check("rx_start", {31'd0, TxD}, 32'd0);
    bits  = '0;
    lowc  = 0;
    busyc = 0;
    for (int c = 0; c < nb * DIV; c++) begin
      if (c % DIV == DIV / 2) bits[c / DIV] = TxD;
      if (TxD == 1'b0) lowc++;
      if (Tx_BUSY) busyc++;
      @(negedge clk);
    end
    check("end_busy", {31'd0, Tx_BUSY}, 32'd0);
    check("end_txd", {31'd0, TxD}, 32'd1);
  endtask

  logic [15:0] bits;
  int          lowc, busyc, waited, hi;
  logic [7:0]  fifo_words [4];

  initial begin
    fifo_words[0] = 8'hA1;
    fifo_words[1] = 8'hB2;
    fifo_words[2] = 8'hC3;
    fifo_words[3] = 8'hD4;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, TxD}, 32'd1);
    check("rst_busy", {31'd0, Tx_BUSY}, 32'd0);
    check("rst_full", {31'd0, Tx_FULL}, 32'd0);
    check("rst_empty", {31'd0, Tx_EMPTY}, 32'd1);
    check("rst_ovf", {31'd0, Tx_OVF}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame 0xFF
    send(8'hFF);
    check("lat_txd", {31'd0, TxD}, 32'd1);
    check("lat_empty", {31'd0, Tx_EMPTY}, 32'd0);
    rx_frame(10, bits, lowc, busyc, waited);
    check("ff_wait", waited, 1);
    check("ff_data", {24'd0, bits[8:1]}, 32'hFF);
    check("ff_low", lowc, DIV);
    check("ff_busy", busyc, 10 * DIV);
    check("ff_stop", {31'd0, bits[9]}, 32'd1);

    // LSB-first order with 0x80
    send(8'h80);
    rx_frame(10, bits, lowc, busyc, waited);
    check("b80_data", {24'd0, bits[8:1]}, 32'h80);
    check("b80_low", lowc, 8 * DIV);
    check("b80_busy", busyc, 10 * DIV);

`ifdef UART_TX_PARITY_EN
    parity_sel = 2'b01;
    send(8'h07);
    rx_frame(11, bits, lowc, busyc, waited);
    check("pe_data", {24'd0, bits[8:1]}, 32'h07);
    check("pe_par", {31'd0, bits[9]}, 32'd1);
    check("pe_busy", busyc, 11 * DIV);
    parity_sel = 2'b10;
    send(8'h07);
    rx_frame(11, bits, lowc, busyc, waited);
    check("po_par", {31'd0, bits[9]}, 32'd0);
    check("po_stop", {31'd0, bits[10]}, 32'd1);
    check("po_busy", busyc, 11 * DIV);
    parity_sel = 2'b00;
`endif

    // FIFO fill with Tx_EN low, then overflow
    Tx_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Tx_DATA = (i < 4) ? fifo_words[i] : 8'hE5;
      Tx_WR   = 1'b1;
      @(negedge clk);
      if (i == 2) check("fill3_full", {31'd0, Tx_FULL}, 32'd0);
      if (i == 3) begin
        check("fill4_full", {31'd0, Tx_FULL}, 32'd1);
        check("fill4_ovf", {31'd0, Tx_OVF}, 32'd0);
      end
      if (i == 4) check("fill5_ovf", {31'd0, Tx_OVF}, 32'd1);
    end
    Tx_WR = 1'b0;
    @(negedge clk);
    check("ovf_pulse", {31'd0, Tx_OVF}, 32'd0);
    check("hold_full", {31'd0, Tx_FULL}, 32'd1);
    check("hold_busy", {31'd0, Tx_BUSY}, 32'd0);
    check("hold_txd", {31'd0, TxD}, 32'd1);

    Tx_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_frame(10, bits, lowc, busyc, waited);
      check("fifo_data", {24'd0, bits[8:1]}, {24'd0, fifo_words[i]});
      check("fifo_gap", waited, 1);
    end
    check("fifo_empty", {31'd0, Tx_EMPTY}, 32'd1);

    // Gating: Tx_EN drops during the first frame
    send(8'h5A);
    send(8'hC3);
    Tx_EN = 1'b0;
    rx_frame(10, bits, lowc, busyc, waited);
    check("gate_data", {24'd0, bits[8:1]}, 32'h5A);
    hi = 0;
    for (int c = 0; c < 1000; c++) begin
      if (TxD && !Tx_BUSY) hi++;
      @(negedge clk);
    end
    check("gate_idle", hi, 1000);
    check("gate_empty", {31'd0, Tx_EMPTY}, 32'd0);
    Tx_EN = 1'b1;
    rx_frame(10, bits, lowc, busyc, waited);
    check("gate_resume", {24'd0, bits[8:1]}, 32'hC3);

    // Reset during the data phase
    send(8'h00);
    send(8'h11);
    repeat (1500) @(negedge clk);
    check("pre_rst_txd", {31'd0, TxD}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_txd", {31'd0, TxD}, 32'd1);
    check("mid_rst_empty", {31'd0, Tx_EMPTY}, 32'd1);
    check("mid_rst_busy", {31'd0, Tx_BUSY}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h96);
    rx_frame(10, bits, lowc, busyc, waited);
    check("post_rst_wait", waited, 1);
    check("post_rst_data", {24'd0, bits[8:1]}, 32'h96);
    check("post_rst_busy", busyc, 10 * DIV);
    check("post_rst_empty", {31'd0, Tx_EMPTY}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
